// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory load/store unit.
package dmem_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Number of bytes moved by an access of the given size; 0 for the illegal code
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    size_to_bytes = 3'd1;
            SZ_H:    size_to_bytes = 3'd2;
            SZ_W:    size_to_bytes = 3'd4;
            default: size_to_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake plus data-memory port of the load/store unit.
// slave is the LSU itself; master is the execute stage together with the memory.
interface dmem_lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_wen;
    logic [1:0]                    req_size;
    logic                          req_unsigned;
    logic [ADDR_WIDTH-1:0]         req_addr;
    logic [DATA_WIDTH-1:0]         req_wdata;

    logic                          resp_valid;
    logic                          resp_ready;
    logic [DATA_WIDTH-1:0]         resp_rdata;
    logic                          resp_err;

    logic                          mem_wen;
    logic [$clog2(DATA_WIDTH)-3:0] mem_wwide;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0]         mem_wdata;
    logic [DATA_WIDTH-1:0]         mem_rdata;

    modport slave (
        input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_wen, mem_wwide, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_wen, mem_wwide, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_load_align.sv
// Big-endian load lane select and sign/zero extension of a fetched memory word.
module dmem_load_align
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            lane,
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane 0 is the most significant byte of the word
    always_comb begin
        unique case (lane)
            2'd0: byte_sel = word[31:24];
            2'd1: byte_sel = word[23:16];
            2'd2: byte_sel = word[15:8];
            default: byte_sel = word[7:0];
        endcase
        half_sel = lane[1] ? word[15:0] : word[31:16];
        case (size)
            SZ_B:    data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_H:    data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            SZ_W:    data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: single-outstanding initiator on the big-endian data memory port.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic        CLK,
    input  logic        RST,
    dmem_lsu_if.slave   bus,
    output logic [15:0] acc_count
);

    localparam logic [ADDR_WIDTH-1:0] A_TWO   = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_THREE = ADDR_WIDTH'(3);

    state_e                state_q, state_d;
    logic                  wen_q, wen_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  req_err;
    logic [DATA_WIDTH-1:0] load_data;

    dmem_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .word        (bus.mem_rdata),
        .lane        (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (load_data)
    );

    // Reject misaligned/illegal requests, and narrow stores whose start address would underflow
    always_comb begin
        case (bus.req_size)
            SZ_B:    req_err = bus.req_wen && (bus.req_addr < A_THREE);
            SZ_H:    req_err = bus.req_addr[0] || (bus.req_wen && (bus.req_addr < A_TWO));
            SZ_W:    req_err = (bus.req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end

    // Next-state, handshake and memory-port decode
    always_comb begin
        state_d        = state_q;
        wen_d          = wen_q;
        size_d         = size_q;
        uns_d          = uns_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        cnt_d          = cnt_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_wen    = 1'b0;
        bus.mem_wwide  = '0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    wen_d   = bus.req_wen;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    err_d   = req_err;
                    state_d = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (wen_q) begin
                    bus.mem_wen   = 1'b1;
                    bus.mem_wwide = size_to_bytes(size_q);
                    bus.mem_wdata = wdata_q;
                    // Memory writes downward from addr+3, so back off so the last byte lands at A
                    case (size_q)
                        SZ_B:    bus.mem_addr = addr_q - A_THREE;
                        SZ_H:    bus.mem_addr = addr_q - A_TWO;
                        default: bus.mem_addr = addr_q;
                    endcase
                end else begin
                    bus.mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                    rdata_d      = load_data;
                end
                state_d = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_d = IDLE;
                    if (!err_q) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched request fields
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign acc_count      = cnt_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a behavioural big-endian byte memory.
module tb_dmem_lsu;
    import dmem_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] acc_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem [0:4103];
    int          rd_a;
    int          wen_cycles = 0;
    logic [11:0] last_addr;
    logic [2:0]  last_wwide;
    logic [31:0] last_wdata;

    dmem_lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus ();

    dmem_lsu #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (12)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .acc_count (acc_count)
    );

    always #5 CLK = ~CLK;

    // Memory write contract: byte i of wdata goes to addr+3-i
    always @(posedge CLK) begin
        if (bus.mem_wen) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(bus.mem_wwide)) begin
                    mem[int'(bus.mem_addr) + 3 - i] <= bus.mem_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_a          = int'(bus.mem_addr);
        bus.mem_rdata = {mem[rd_a], mem[rd_a+1], mem[rd_a+2], mem[rd_a+3]};
    end

    // Record write-enable cycles mid-cycle
    always @(negedge CLK) begin
        if (bus.mem_wen) begin
            wen_cycles <= wen_cycles + 1;
            last_addr  <= bus.mem_addr;
            last_wwide <= bus.mem_wwide;
            last_wdata <= bus.mem_wdata;
        end
    end

    task automatic send_req(input logic wen, input logic [1:0] size, input logic uns,
                            input logic [11:0] addr, input logic [31:0] wdata);
        bus.req_wen      = wen;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        @(posedge CLK);
        #1;
        bus.req_valid    = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge CLK);
            #1;
            lat++;
        end
    endtask

    task automatic end_resp;
        bus.resp_ready = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++;
            $display("FAIL rst_req_ready got %b want 1", bus.req_ready); end
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++;
            $display("FAIL rst_resp_valid got %b want 0", bus.resp_valid); end
        n_checks++; if (bus.resp_err !== 1'b0) begin n_fail++;
            $display("FAIL rst_resp_err got %b want 0", bus.resp_err); end
        n_checks++; if (bus.resp_rdata !== 32'h0) begin n_fail++;
            $display("FAIL rst_resp_rdata got %h want 0", bus.resp_rdata); end
        n_checks++; if (acc_count !== 16'h0) begin n_fail++;
            $display("FAIL rst_acc_count got %h want 0", acc_count); end
        n_checks++;
        if ({bus.mem_wen, bus.mem_wwide, bus.mem_addr, bus.mem_wdata} !== '0) begin n_fail++;
            $display("FAIL rst_mem_outputs got wen=%b wwide=%0d addr=%h wdata=%h want all 0",
                     bus.mem_wen, bus.mem_wwide, bus.mem_addr, bus.mem_wdata);
        end
        RST = 1'b0;
    endtask

    task automatic test_loads;
        logic [1:0]  sz  [5] = '{SZ_W, SZ_B, SZ_B, SZ_H, SZ_H};
        logic        uns [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [11:0] adr [5] = '{12'h100, 12'h102, 12'h102, 12'h102, 12'h100};
        logic [31:0] exp [5] = '{32'h11228344, 32'hFFFFFF83, 32'h00000083,
                                 32'hFFFF8344, 32'h00001122};
        int lat;
        int w0;
        for (int k = 0; k < 5; k++) begin
            w0 = wen_cycles;
            send_req(1'b0, sz[k], uns[k], adr[k], 32'hFFFFFFFF);
            wait_resp(lat);
            n_checks++; if (lat !== 2) begin n_fail++;
                $display("FAIL load%0d_latency got %0d want 2", k, lat); end
            n_checks++; if (bus.resp_rdata !== exp[k]) begin n_fail++;
                $display("FAIL load%0d_rdata got %h want %h", k, bus.resp_rdata, exp[k]); end
            n_checks++; if (bus.resp_err !== 1'b0) begin n_fail++;
                $display("FAIL load%0d_err got %b want 0", k, bus.resp_err); end
            end_resp();
            n_checks++; if (wen_cycles !== w0) begin n_fail++;
                $display("FAIL load%0d_no_write got %0d wen cycles want 0", k, wen_cycles - w0); end
        end
        n_checks++; if (acc_count !== 16'd5) begin n_fail++;
            $display("FAIL load_count got %0d want 5", acc_count); end
    endtask

    task automatic test_stores;
        int lat;
        int w0;
        w0 = wen_cycles;
        send_req(1'b1, SZ_B, 1'b0, 12'h105, 32'hAABBCCDD);
        wait_resp(lat);
        n_checks++; if (lat !== 2 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL sb_resp got lat=%0d err=%b rdata=%h want 2/0/0",
                               lat, bus.resp_err, bus.resp_rdata); end
        n_checks++; if (wen_cycles - w0 !== 1) begin n_fail++;
            $display("FAIL sb_wen_cycles got %0d want 1", wen_cycles - w0); end
        n_checks++;
        if (last_addr !== 12'h102 || last_wwide !== 3'd1 || last_wdata !== 32'hAABBCCDD) begin
            n_fail++; $display("FAIL sb_mem_port got addr=%h wwide=%0d wdata=%h want 102/1/aabbccdd",
                               last_addr, last_wwide, last_wdata); end
        end_resp();
        n_checks++; if ({mem[12'h104], mem[12'h105], mem[12'h106]} !== 24'h00DD00) begin n_fail++;
            $display("FAIL sb_mem got %h%h%h want 00dd00", mem[12'h104], mem[12'h105], mem[12'h106]);
        end

        w0 = wen_cycles;
        send_req(1'b1, SZ_H, 1'b0, 12'h106, 32'h00001234);
        wait_resp(lat);
        n_checks++; if (lat !== 2 || bus.resp_err !== 1'b0) begin n_fail++;
            $display("FAIL sh_resp got lat=%0d err=%b want 2/0", lat, bus.resp_err); end
        n_checks++;
        if (wen_cycles - w0 !== 1 || last_addr !== 12'h104 || last_wwide !== 3'd2) begin n_fail++;
            $display("FAIL sh_mem_port got cycles=%0d addr=%h wwide=%0d want 1/104/2",
                     wen_cycles - w0, last_addr, last_wwide); end
        end_resp();
        n_checks++;
        if ({mem[12'h105], mem[12'h106], mem[12'h107], mem[12'h108]} !== 32'hDD123400) begin
            n_fail++; $display("FAIL sh_mem got %h%h%h%h want dd123400",
                               mem[12'h105], mem[12'h106], mem[12'h107], mem[12'h108]); end
        n_checks++; if (acc_count !== 16'd7) begin n_fail++;
            $display("FAIL store_count got %0d want 7", acc_count); end
    endtask

    task automatic test_errors;
        logic        wn  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0]  sz  [5] = '{SZ_W, SZ_H, 2'd3, SZ_B, SZ_H};
        logic [11:0] adr [5] = '{12'h101, 12'h103, 12'h100, 12'h001, 12'h000};
        int lat;
        int w0;
        for (int k = 0; k < 5; k++) begin
            w0 = wen_cycles;
            send_req(wn[k], sz[k], 1'b0, adr[k], 32'h5A5A5A5A);
            wait_resp(lat);
            n_checks++;
            if (lat !== 1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'h0) begin n_fail++;
                $display("FAIL err%0d_resp got lat=%0d err=%b rdata=%h want 1/1/0",
                         k, lat, bus.resp_err, bus.resp_rdata); end
            end_resp();
            n_checks++; if (wen_cycles !== w0 || acc_count !== 16'd7) begin n_fail++;
                $display("FAIL err%0d_side_effects got wen=%0d count=%0d want 0/7",
                         k, wen_cycles - w0, acc_count); end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        int w0;
        bus.resp_ready = 1'b0;
        send_req(1'b0, SZ_W, 1'b0, 12'h100, 32'h0);
        wait_resp(lat);
        w0 = wen_cycles;
        n_checks++; if (lat !== 2) begin n_fail++;
            $display("FAIL bp_latency got %0d want 2", lat); end
        for (int c = 0; c < 5; c++) begin
            bus.req_valid = 1'b1;
            bus.req_wen   = 1'b1;
            bus.req_size  = SZ_W;
            bus.req_addr  = 12'h200;
            @(posedge CLK);
            #1;
            bus.req_valid = 1'b0;
            n_checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h11228344 ||
                bus.req_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d got valid=%b rdata=%h ready=%b want 1/11228344/0",
                                   c, bus.resp_valid, bus.resp_rdata, bus.req_ready); end
        end
        n_checks++; if (wen_cycles !== w0 || acc_count !== 16'd7) begin n_fail++;
            $display("FAIL bp_ignored got wen=%0d count=%0d want 0/7", wen_cycles - w0, acc_count);
        end
        end_resp();
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || acc_count !== 16'd8) begin
            n_fail++; $display("FAIL bp_release got ready=%b valid=%b count=%0d want 1/0/8",
                               bus.req_ready, bus.resp_valid, acc_count); end
    endtask

    task automatic test_reset_mid;
        int lat;
        send_req(1'b1, SZ_W, 1'b0, 12'h200, 32'hDEADBEEF);
        n_checks++; if (bus.mem_wen !== 1'b1) begin n_fail++;
            $display("FAIL rmid_access_wen got %b want 1", bus.mem_wen); end
        RST = 1'b1;
        #1;
        n_checks++; if (bus.mem_wen !== 1'b0 || bus.mem_addr !== 12'h0 || bus.mem_wdata !== 32'h0)
        begin n_fail++; $display("FAIL rmid_mem_drop got wen=%b addr=%h wdata=%h want 0/0/0",
                                 bus.mem_wen, bus.mem_addr, bus.mem_wdata); end
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || acc_count !== 16'h0) begin
            n_fail++; $display("FAIL rmid_state got ready=%b valid=%b count=%0d want 1/0/0",
                               bus.req_ready, bus.resp_valid, acc_count); end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        n_checks++;
        if ({mem[12'h200], mem[12'h201], mem[12'h202], mem[12'h203]} !== 32'h55667788) begin
            n_fail++; $display("FAIL rmid_mem got %h%h%h%h want 55667788",
                               mem[12'h200], mem[12'h201], mem[12'h202], mem[12'h203]); end
        send_req(1'b0, SZ_W, 1'b0, 12'h200, 32'h0);
        wait_resp(lat);
        n_checks++; if (lat !== 2 || bus.resp_rdata !== 32'h55667788) begin n_fail++;
            $display("FAIL rmid_after got lat=%0d rdata=%h want 2/55667788", lat, bus.resp_rdata);
        end
        end_resp();
    endtask

    task automatic test_back_to_back;
        logic [1:0]  sz  [5] = '{SZ_W, SZ_B, SZ_W, SZ_H, SZ_W};
        logic [11:0] adr [5] = '{12'h100, 12'h002, 12'h100, 12'h101, 12'h104};
        int lat;
        RST = 1'b1;
        #2;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        for (int k = 0; k < 10; k++) begin
            send_req(1'b0, SZ_B, 1'b0, 12'(12'h100 + k), 32'h0);
            wait_resp(lat);
            end_resp();
        end
        n_checks++; if (acc_count !== 16'd10) begin n_fail++;
            $display("FAIL b2b_count got %0d want 10", acc_count); end
        // ok, err (byte store at 2), ok, err (odd half), ok
        for (int k = 0; k < 5; k++) begin
            send_req((k == 1), sz[k], 1'b0, adr[k], 32'h0);
            wait_resp(lat);
            end_resp();
        end
        n_checks++; if (acc_count !== 16'd13) begin n_fail++;
            $display("FAIL mixed_count got %0d want 13", acc_count); end
    endtask

    initial begin
        RST              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_wen      = 1'b0;
        bus.req_size     = SZ_B;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.resp_ready   = 1'b1;
        for (int i = 0; i < 4104; i++) begin
            mem[i] <= 8'h00;
        end
        mem[12'h100] <= 8'h11;
        mem[12'h101] <= 8'h22;
        mem[12'h102] <= 8'h83;
        mem[12'h103] <= 8'h44;
        mem[12'h200] <= 8'h55;
        mem[12'h201] <= 8'h66;
        mem[12'h202] <= 8'h77;
        mem[12'h203] <= 8'h88;
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        @(posedge CLK);
        #1;
        test_loads();
        test_stores();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
